// File: rtl/timing_nco_mu_if.sv
// Sample/error handshake between the timing-error detector, the timing NCO
// and the Farrow interpolator.
interface timing_nco_mu_if #(
  parameter int W = 19
);
  logic                in_valid;
  logic signed [W-1:0] err;
  logic                err_valid;
  logic                strobe;
  logic signed [W-1:0] mu;
  logic signed [W-1:0] lf_out;

  // Upstream side: supplies samples and TED error, observes the NCO.
  modport master (
    output in_valid,
    output err,
    output err_valid,
    input  strobe,
    input  mu,
    input  lf_out
  );

  // NCO side.
  modport slave (
    input  in_valid,
    input  err,
    input  err_valid,
    output strobe,
    output mu,
    output lf_out
  );
endinterface

// File: rtl/timing_nco_mu.sv
// Symbol-timing control: PI loop filter on the TED error plus a modulo-1
// decrementing NCO that emits an interpolant strobe and fractional interval mu.
module timing_nco_mu #(
  parameter int W        = 19,
  parameter int FRAC     = 17,
  parameter int SPS_LOG2 = 1,
  parameter int KP_SHIFT = 4,
  parameter int KI_SHIFT = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  timing_nco_mu_if.slave bus
);

  // Two guard bits cover every intermediate sum before clamping.
  localparam int WX = W + 2;

  localparam logic signed [WX-1:0] SAT_HI = WX'((longint'(1) <<< (W - 1)) - 1);
  localparam logic signed [WX-1:0] SAT_LO = WX'(-(longint'(1) <<< (W - 1)));
  localparam logic signed [WX-1:0] ONE    = WX'(longint'(1) <<< FRAC);
  localparam logic signed [WX-1:0] MU_MAX = WX'((longint'(1) <<< FRAC) - 1);
  localparam logic signed [WX-1:0] W_NOM  = WX'(longint'(1) <<< (FRAC - SPS_LOG2));
  localparam logic signed [WX-1:0] WK_MIN = WX'(1);

  localparam logic signed [W-1:0]  ETA_RST = W'((longint'(1) <<< FRAC) - 1);

  function automatic logic signed [WX-1:0] sext(input logic signed [W-1:0] x);
    return {{2{x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [WX-1:0] x);
    logic signed [WX-1:0] c;
    c = x;
    if (x > SAT_HI) c = SAT_HI;
    else if (x < SAT_LO) c = SAT_LO;
    return W'(c);
  endfunction

  // Registered state
  logic signed [W-1:0] integ_q;
  logic signed [W-1:0] v_q;
  logic signed [W-1:0] eta_q;
  logic signed [W-1:0] mu_q;
  logic                strobe_q;

  // Loop-filter datapath
  logic signed [WX-1:0] err_x;
  logic signed [WX-1:0] err_kp;
  logic signed [WX-1:0] err_ki;
  logic signed [W-1:0]  integ_new;
  logic signed [W-1:0]  v_new;

  // NCO datapath
  logic signed [WX-1:0] wk_raw;
  logic signed [WX-1:0] wk;
  logic signed [WX-1:0] d;
  logic                 underflow;
  logic signed [W-1:0]  eta_next;
  logic signed [WX-1:0] mu_cand;
  logic signed [W-1:0]  mu_next;

  // PI loop filter: gains are arithmetic right shifts, both terms saturate.
  always_comb begin
    err_x     = sext(bus.err);
    err_kp    = err_x >>> KP_SHIFT;
    err_ki    = err_x >>> KI_SHIFT;
    integ_new = sat_w(sext(integ_q) + err_ki);
    v_new     = sat_w(err_kp + sext(integ_new));
  end

  // NCO step from the registered filter output, clamped into [1, 1.0 - lsb];
  // underflow wraps modulo 1.0 and yields mu from the pre-decrement eta.
  always_comb begin
    wk_raw = W_NOM + sext(v_q);
    wk     = wk_raw;
    if (wk_raw < WK_MIN)      wk = WK_MIN;
    else if (wk_raw > MU_MAX) wk = MU_MAX;

    d         = sext(eta_q) - wk;
    underflow = d[WX-1];
    eta_next  = underflow ? W'(d + ONE) : W'(d);

    mu_cand = sext(eta_q) <<< SPS_LOG2;
    mu_next = (mu_cand > MU_MAX) ? W'(MU_MAX) : W'(mu_cand);
  end

  // Loop-filter registers advance only on a valid TED error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
      v_q     <= '0;
    end else if (bus.err_valid) begin
      integ_q <= integ_new;
      v_q     <= v_new;
    end
  end

  // NCO registers advance only on an accepted input sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eta_q    <= ETA_RST;
      mu_q     <= '0;
      strobe_q <= 1'b0;
    end else if (bus.in_valid) begin
      eta_q    <= eta_next;
      strobe_q <= underflow;
      if (underflow) mu_q <= mu_next;
    end else begin
      strobe_q <= 1'b0;
    end
  end

  assign bus.strobe = strobe_q;
  assign bus.mu     = mu_q;
  assign bus.lf_out = v_q;

endmodule

// File: tb/tb_timing_nco_mu.sv
// Bench for timing_nco_mu: arithmetic reference model compared every cycle,
// plus hand-computed checkpoints for each scenario.
module tb_timing_nco_mu;

  localparam int W        = 19;
  localparam int FRAC     = 17;
  localparam int SPS_LOG2 = 1;
  localparam int KP_SHIFT = 4;
  localparam int KI_SHIFT = 10;

  localparam int ONE   = 1 << FRAC;
  localparam int WNOM  = 1 << (FRAC - SPS_LOG2);
  localparam int S_MAX = (1 << (W - 1)) - 1;
  localparam int S_MIN = -(1 << (W - 1));

  logic clk;
  logic rst_n;

  timing_nco_mu_if #(.W(W)) bus ();

  timing_nco_mu #(
    .W(W), .FRAC(FRAC), .SPS_LOG2(SPS_LOG2), .KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int floor_pow2(input int a, input int k);
    int den;
    den = 1 << k;
    if (a >= 0) return a / den;
    return -((-a + den - 1) / den);
  endfunction

  function automatic int clampi(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  int m_eta, m_integ, m_v, m_mu, m_strobe;

  always @(posedge clk or negedge rst_n) begin
    int wk, e;
    if (!rst_n) begin
      m_eta = ONE - 1; m_integ = 0; m_v = 0; m_mu = 0; m_strobe = 0;
    end else begin
      wk = clampi(WNOM + m_v, 1, ONE - 1);
      e  = int'($signed(bus.err));
      if (bus.err_valid) begin
        m_integ = clampi(m_integ + floor_pow2(e, KI_SHIFT), S_MIN, S_MAX);
        m_v     = clampi(floor_pow2(e, KP_SHIFT) + m_integ, S_MIN, S_MAX);
      end
      if (bus.in_valid) begin
        if (m_eta - wk < 0) begin
          m_mu     = (m_eta * (1 << SPS_LOG2) > ONE - 1) ? ONE - 1 : m_eta * (1 << SPS_LOG2);
          m_eta    = m_eta - wk + ONE;
          m_strobe = 1;
        end else begin
          m_eta    = m_eta - wk;
          m_strobe = 0;
        end
      end else begin
        m_strobe = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("strobe", int'(bus.strobe), m_strobe);
    check("mu", int'($signed(bus.mu)), m_mu);
    check("lf_out", int'($signed(bus.lf_out)), m_v);
    check("mu_msb", int'(bus.mu[W-1]), 0);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic iv, input logic ev, input int e);
    bus.in_valid  = iv;
    bus.err_valid = ev;
    bus.err       = W'(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.err_valid = 1'b0; bus.err = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Power-up sequence: strobe on every second sample with mu = 131070.
  task automatic run_nominal(input string tag);
    step(1'b1, 1'b0, 0);
    check({tag, "_s1_strobe"}, int'(bus.strobe), 0);
    step(1'b1, 1'b0, 0);
    check({tag, "_s2_strobe"}, int'(bus.strobe), 1);
    check({tag, "_s2_mu"}, int'($signed(bus.mu)), 131070);
    step(1'b1, 1'b0, 0);
    check({tag, "_s3_strobe"}, int'(bus.strobe), 0);
    step(1'b1, 1'b0, 0);
    check({tag, "_s4_strobe"}, int'(bus.strobe), 1);
    check({tag, "_s4_mu"}, int'($signed(bus.mu)), 131070);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.err_valid = 1'b0; bus.err = '0;
    #2;
    check("rst_strobe", int'(bus.strobe), 0);
    check("rst_mu", int'($signed(bus.mu)), 0);
    check("rst_lf", int'($signed(bus.lf_out)), 0);
    do_reset();

    // 1: nominal free-run
    run_nominal("t1");

    // 2: in_valid toggling, idle cycles hold everything
    do_reset();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step((i % 2) == 0, 1'b0, 0);
      cnt += int'(bus.strobe);
      if (i == 3) check("t2_idle_mu", int'($signed(bus.mu)), 131070);
    end
    check("t2_strobes", cnt, 2);

    // 3: loop filter arithmetic
    do_reset();
    step(1'b0, 1'b1, 4096);
    check("t3_lf1", int'($signed(bus.lf_out)), 260);
    step(1'b0, 1'b1, 4096);
    check("t3_lf2", int'($signed(bus.lf_out)), 264);
    step(1'b0, 1'b1, 4096);
    check("t3_lf3", int'($signed(bus.lf_out)), 268);
    step(1'b1, 1'b0, 0);   // eta 131071 - 65804 = 65267
    step(1'b1, 1'b0, 0);   // underflow, mu = 2*65267
    check("t3_strobe", int'(bus.strobe), 1);
    check("t3_mu", int'($signed(bus.mu)), 130534);

    // 4: saturation both ways and Wk clamps
    do_reset();
    for (int i = 0; i < 1100; i++) step(1'b0, 1'b1, -262144);
    check("t4_lf_neg", int'($signed(bus.lf_out)), -262144);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, -262144);
      cnt += int'(bus.strobe);
    end
    check("t4_no_strobe", cnt, 0);
    for (int i = 0; i < 2100; i++) step(1'b0, 1'b1, 262143);
    check("t4_lf_pos", int'($signed(bus.lf_out)), 262143);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 0);
      cnt += int'(bus.strobe);
    end
    check("t4_all_strobe", cnt, 20);
    check("t4_mu", int'($signed(bus.mu)), 131071);

    // 5: coincident err_valid/in_valid uses the old v
    do_reset();
    step(1'b1, 1'b1, 65536);   // Wk = 65536: eta -> 65535
    check("t5_s1_strobe", int'(bus.strobe), 0);
    check("t5_lf", int'($signed(bus.lf_out)), 4160);
    step(1'b1, 1'b0, 0);       // Wk = 69696: underflow, eta -> 126911
    check("t5_s2_strobe", int'(bus.strobe), 1);
    check("t5_s2_mu", int'($signed(bus.mu)), 131070);
    step(1'b1, 1'b0, 0);       // eta -> 57215
    step(1'b1, 1'b0, 0);       // underflow, mu = 2*57215
    check("t5_s4_strobe", int'(bus.strobe), 1);
    check("t5_s4_mu", int'($signed(bus.mu)), 114430);

    // 6: asynchronous reset while strobe is high
    do_reset();
    step(1'b0, 1'b1, 8192);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    check("t6_pre_strobe", int'(bus.strobe), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_strobe", int'(bus.strobe), 0);
    check("t6_rst_mu", int'($signed(bus.mu)), 0);
    check("t6_rst_lf", int'($signed(bus.lf_out)), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_nominal("t6");

    step(1'b0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
